bcd_mod_counter: RTL

- Parametrised two-digit BCD modulo counter; the generic successor to the per-field clock counters (seconds, minutes, hours, day, month).
- Configurable range MIN_VAL..MAX_VAL, with an optional runtime maximum (days-in-month).
- Set mode supports edge-triggered stepping with auto-repeat when a button is held.
- Cascades through a registered one-cycle carry pulse into the next field's tick input.

---
 rtl/clock_pkg.sv | 56 +++++
 rtl/key_repeat.sv | 96 +++++++++
 rtl/bcd_mod_counter.sv | 112 +++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared types and BCD helpers for the clock/calendar field counters.
// Values are carried as two packed BCD digits {ten, unit}.
package clock_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        KEY_IDLE = 2'd0,
        KEY_UP   = 2'd1,
        KEY_DOWN = 2'd2
    } key_dir_e;

    localparam int SEC_MIN_VAL   = 0;
    localparam int SEC_MAX_VAL   = 59;
    localparam int MIN_MIN_VAL   = 0;
    localparam int MIN_MAX_VAL   = 59;
    localparam int HOUR_MIN_VAL  = 0;
    localparam int HOUR_MAX_VAL  = 23;
    localparam int DAY_MIN_VAL   = 1;
    localparam int DAY_MAX_VAL   = 31;
    localparam int MONTH_MIN_VAL = 1;
    localparam int MONTH_MAX_VAL = 12;

    function automatic logic [7:0] bcd_inc2(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    function automatic logic [7:0] bcd_dec2(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd0) begin
            r = {v[7:4] - 4'd1, 4'd9};
        end else begin
            r = {v[7:4], v[3:0] - 4'd1};
        end
        return r;
    endfunction

    function automatic logic bcd_valid2(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    function automatic logic [7:0] to_bcd2(input int v);
        bcd_digit_t t;
        bcd_digit_t u;
        t = bcd_digit_t'(v / 10);
        u = bcd_digit_t'(v % 10);
        return {t, u};
    endfunction

endpackage

// File: rtl/key_repeat.sv
// Up/down key stepping: one step on press or direction change, then auto-repeat
// after REPEAT_DELAY held cycles every REPEAT_PERIOD cycles. Active only in set mode.
module key_repeat
    import clock_pkg::*;
#(
    parameter int REPEAT_DELAY  = 50,
    parameter int REPEAT_PERIOD = 10
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic mode_run_i,
    input  logic up_i,
    input  logic down_i,
    output logic step_up_o,
    output logic step_down_o
);

    localparam int DLY_W = $clog2(REPEAT_DELAY + 2);
    localparam int PER_W = $clog2(REPEAT_PERIOD + 2);

    key_dir_e         prev_q, prev_d, dir_s, prev_eff_s;
    logic             lock_q, lock_d, lock_eff_s;
    logic             mode_q;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic [PER_W-1:0] per_q, per_d;
    logic             active_s, mode_chg_s, step_s;

    // Key decode, hold/repeat counters and step strobe
    always_comb begin
        active_s   = up_i ^ down_i;
        if (!active_s) begin
            dir_s = KEY_IDLE;
        end else if (up_i) begin
            dir_s = KEY_UP;
        end else begin
            dir_s = KEY_DOWN;
        end
        mode_chg_s = (mode_run_i != mode_q);
        prev_eff_s = mode_chg_s ? KEY_IDLE : prev_q;
        lock_eff_s = mode_chg_s ? 1'b0 : lock_q;

        prev_d = KEY_IDLE;
        lock_d = 1'b0;
        dly_d  = '0;
        per_d  = '0;
        step_s = 1'b0;

        if (mode_run_i || !active_s) begin
            lock_d = 1'b0;
        end else if (lock_eff_s) begin
            // key held through reset stays inert until released
            lock_d = 1'b1;
        end else if (prev_eff_s != dir_s) begin
            step_s = 1'b1;
            prev_d = dir_s;
            dly_d  = (REPEAT_DELAY > 0) ? DLY_W'(1) : '0;
        end else begin
            prev_d = prev_eff_s;
            if (REPEAT_DELAY == 0) begin
                dly_d = dly_q;
                per_d = per_q;
            end else if (dly_q != DLY_W'(REPEAT_DELAY)) begin
                dly_d = dly_q + DLY_W'(1);
            end else begin
                dly_d = dly_q;
                if ((per_q == '0) || (per_q == PER_W'(REPEAT_PERIOD))) begin
                    step_s = 1'b1;
                    per_d  = PER_W'(1);
                end else begin
                    per_d  = per_q + PER_W'(1);
                end
            end
        end

        step_up_o   = step_s && (dir_s == KEY_UP);
        step_down_o = step_s && (dir_s == KEY_DOWN);
    end

    // Repeat state registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q <= KEY_IDLE;
            lock_q <= up_i ^ down_i;
            mode_q <= mode_run_i;
            dly_q  <= '0;
            per_q  <= '0;
        end else begin
            prev_q <= prev_d;
            lock_q <= lock_d;
            mode_q <= mode_run_i;
            dly_q  <= dly_d;
            per_q  <= per_d;
        end
    end

endmodule

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter for one clock/calendar field: run-mode ticking with
// registered carry, set-mode up/down editing, and an optional runtime maximum.
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter int MIN_VAL       = 0,
    parameter int MAX_VAL       = 59,
    parameter int USE_DYN_MAX   = 0,
    parameter int REPEAT_DELAY  = 50,
    parameter int REPEAT_PERIOD = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_run,
    input  logic       tick_in,
    input  logic       up,
    input  logic       down,
    input  logic [7:0] max_dyn,
    output logic [3:0] value_unit,
    output logic [3:0] value_ten,
    output logic       carry_out,
    output logic       edit_pulse
);

    generate
        if (MIN_VAL >= MAX_VAL) begin : g_err_range
            $error("bcd_mod_counter: MIN_VAL must be below MAX_VAL");
        end
        if (MAX_VAL > 99) begin : g_err_max
            $error("bcd_mod_counter: MAX_VAL must not exceed 99");
        end
        if (REPEAT_PERIOD == 0) begin : g_err_period
            $error("bcd_mod_counter: REPEAT_PERIOD must be at least 1");
        end
    endgenerate

    localparam logic [7:0] MIN_BCD = to_bcd2(MIN_VAL);
    localparam logic [7:0] MAX_BCD = to_bcd2(MAX_VAL);

    logic [7:0] value_q, value_d, max_eff_s;
    logic       carry_q, carry_d, edit_q, edit_d;
    logic       step_up_s, step_down_s;

    key_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_key_repeat (
        .clk_i      (clk),
        .rst_i      (rst),
        .mode_run_i (mode_run),
        .up_i       (up),
        .down_i     (down),
        .step_up_o  (step_up_s),
        .step_down_o(step_down_s)
    );

    // Effective maximum: an unusable runtime maximum falls back to MAX_VAL
    always_comb begin
        if ((USE_DYN_MAX != 0) && bcd_valid2(max_dyn) &&
            (max_dyn >= MIN_BCD) && (max_dyn <= MAX_BCD)) begin
            max_eff_s = max_dyn;
        end else begin
            max_eff_s = MAX_BCD;
        end
    end

    // Next value: clamp first, then run-mode tick or set-mode step
    always_comb begin
        value_d = value_q;
        carry_d = 1'b0;
        edit_d  = 1'b0;
        if (value_q > max_eff_s) begin
            value_d = max_eff_s;
        end else if (mode_run) begin
            if (!tick_in) begin
                value_d = value_q;
            end else if (value_q == max_eff_s) begin
                value_d = MIN_BCD;
                carry_d = 1'b1;
            end else begin
                value_d = bcd_inc2(value_q);
            end
        end else if (step_up_s) begin
            value_d = (value_q == max_eff_s) ? MIN_BCD : bcd_inc2(value_q);
            edit_d  = 1'b1;
        end else if (step_down_s) begin
            value_d = (value_q == MIN_BCD) ? max_eff_s : bcd_dec2(value_q);
            edit_d  = 1'b1;
        end else begin
            value_d = value_q;
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= MIN_BCD;
            carry_q <= 1'b0;
            edit_q  <= 1'b0;
        end else begin
            value_q <= value_d;
            carry_q <= carry_d;
            edit_q  <= edit_d;
        end
    end

    assign value_unit = value_q[3:0];
    assign value_ten  = value_q[7:4];
    assign carry_out  = carry_q;
    assign edit_pulse = edit_q;

endmodule
